tap_clk_gen: RTL and testbench

Runtime-programmable, glitch-free TAP clock generator for the CRCU. It divides CRCU_CLK by a divisor chosen from a parameter table using the `tap_clock_ctl_reg` select field, and honours the enable and gate bits. Divisor changes and stops are deferred to a period boundary, so `tap_clk` never produces a runt pulse. It sits between the APB register file and the JTAG/TAP logic and drives `tap_clk` as a plain 0/1 signal, never Z.

---
 rtl/crcu_clk_pkg.sv | 24 ++
 rtl/tap_div_counter.sv | 56 +++++
 rtl/tap_clk_gen.sv | 123 ++++++++++++
 tb/tb_tap_clk_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crcu_clk_pkg.sv
// +----------------------------------------------------------------------+
// | crcu_clk_pkg: shared constants for the CRCU TAP clock generator.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package crcu_clk_pkg;

  typedef logic [0:0] tap_state_t;
  localparam tap_state_t TAP_OFF = 1'b0;
  localparam tap_state_t TAP_RUN = 1'b1;

  localparam int TAP_SEL_LSB  = 0;
  localparam int TAP_SEL_W    = 3;
  localparam int TAP_EN_BIT   = 3;
  localparam int TAP_GATE_BIT = 4;
  localparam int TAP_CTL_W    = 5;

  // Index 4..0 reading left to right: select 0 is the slowest (divide by 120).
  localparam logic [4:0][7:0] TAP_DIV_TABLE_DEFAULT = {8'd12, 8'd15, 8'd30, 8'd48, 8'd120};

endpackage

`default_nettype wire

// File: rtl/tap_div_counter.sv
// +----------------------------------------------------------------------+
// | tap_div_counter: period counter, high/low phase and boundary flag.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tap_div_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] n_act,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             hi,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             hi_q, hi_d;
  logic [CNT_W-1:0] half;

  assign half = n_act - (n_act >> 1);
  assign wrap = run_q && (cnt_q == n_act - CNT_W'(1));

  // `run` is the state for the coming cycle; `n_act` is the divisor of the
  // period in progress. A fresh period always starts high, so the new
  // divisor is never needed to compute the phase at cnt=0.
  always_comb begin
    run_d = run;
    cnt_d = '0;
    if (run && run_q && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    hi_d = run && ((cnt_d == '0) || (cnt_d < half));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      hi_q  <= hi_d;
    end
  end

  assign cnt = cnt_q;
  assign hi  = hi_q;

endmodule

`default_nettype wire

// File: rtl/tap_clk_gen.sv
// +----------------------------------------------------------------------+
// | tap_clk_gen: glitch-free programmable TAP clock divider for the CRCU.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tap_clk_gen
  import crcu_clk_pkg::*;
#(
  parameter int                              NUM_SEL   = 5,
  parameter int                              CNT_W     = 8,
  parameter logic [NUM_SEL-1:0][CNT_W-1:0] DIV_TABLE = TAP_DIV_TABLE_DEFAULT
) (
  input  logic        CRCU_CLK,
  input  logic        CRCU_RST_N,
  input  logic [31:0] tap_clock_ctl_reg,
  output logic        tap_clk,
  output logic        tap_clk_active,
  output logic        tap_switch_busy,
  output logic        tap_cfg_err
);

  localparam logic [3:0] NUM_SEL_C = NUM_SEL[3:0];

  if (NUM_SEL < 1 || NUM_SEL > 8) begin : g_bad_num_sel
    $error("tap_clk_gen: NUM_SEL must be in 1..8");
  end

  for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_div_check
    if (DIV_TABLE[gi] < CNT_W'(2)) begin : g_bad_div
      $error("tap_clk_gen: DIV_TABLE entries must be >= 2");
    end
  end

  logic [TAP_CTL_W-1:0] ctl_q, ctl_d;
  tap_state_t           state_q, state_d;
  logic [CNT_W-1:0]     n_act_q, n_act_d;

  logic [TAP_SEL_W-1:0] sel;
  logic                 sel_valid;
  logic                 req;
  logic [CNT_W-1:0]     div_sel;
  logic [CNT_W-1:0]     cnt;
  logic                 hi;
  logic                 wrap;
  logic                 ctl_unused;

  assign ctl_unused = ^tap_clock_ctl_reg[31:TAP_CTL_W];
  assign ctl_d      = tap_clock_ctl_reg[TAP_CTL_W-1:0];

  assign sel       = ctl_q[TAP_SEL_LSB +: TAP_SEL_W];
  assign sel_valid = {1'b0, sel} < NUM_SEL_C;
  assign req       = ctl_q[TAP_EN_BIT] && !ctl_q[TAP_GATE_BIT] && sel_valid;

  // Out-of-range codes fall back to entry 0; they never reach the counter
  // because req is low for them.
  always_comb begin
    div_sel = DIV_TABLE[0];
    for (int i = 0; i < NUM_SEL; i++) begin
      if (sel == TAP_SEL_W'(i)) begin
        div_sel = DIV_TABLE[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    n_act_d = n_act_q;
    case (state_q)
      TAP_OFF: begin
        if (req) begin
          state_d = TAP_RUN;
          n_act_d = div_sel;
        end
      end
      TAP_RUN: begin
        if (wrap) begin
          if (!req) begin
            state_d = TAP_OFF;
          end else begin
            n_act_d = div_sel;
          end
        end
      end
      default: state_d = TAP_OFF;
    endcase
  end

  always_ff @(posedge CRCU_CLK) begin
    if (!CRCU_RST_N) begin
      ctl_q   <= '0;
      state_q <= TAP_OFF;
      n_act_q <= '0;
    end else begin
      ctl_q   <= ctl_d;
      state_q <= state_d;
      n_act_q <= n_act_d;
    end
  end

  tap_div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .clk   (CRCU_CLK),
    .rst_n (CRCU_RST_N),
    .n_act (n_act_q),
    .run   (state_d == TAP_RUN),
    .cnt   (cnt),
    .hi    (hi),
    .wrap  (wrap)
  );

  logic cnt_unused;
  assign cnt_unused = ^cnt;

  assign tap_clk         = hi;
  assign tap_clk_active  = (state_q == TAP_RUN);
  assign tap_switch_busy = (state_q == TAP_RUN) && (!req || (div_sel != n_act_q));
  assign tap_cfg_err     = !sel_valid;

endmodule

`default_nettype wire

// File: tb/tb_tap_clk_gen.sv
// +----------------------------------------------------------------------+
// | tb_tap_clk_gen: directed self-checking bench for tap_clk_gen.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tap_clk_gen;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [31:0] ctl, ctl2;
  logic        tclk, act, busy, err;
  logic        tclk2, act2, busy2, err2;

  int checks = 0;
  int errors = 0;

  // Period-measurement schedule: up to two control writes at given sample indices.
  int          pa, pb, pidx;
  logic [31:0] pav, pbv;
  logic        pbm;

  always #5 clk = ~clk;

  tap_clk_gen u_dut (
    .CRCU_CLK          (clk),
    .CRCU_RST_N        (rst_n),
    .tap_clock_ctl_reg (ctl),
    .tap_clk           (tclk),
    .tap_clk_active    (act),
    .tap_switch_busy   (busy),
    .tap_cfg_err       (err)
  );

  tap_clk_gen #(
    .NUM_SEL   (1),
    .CNT_W     (8),
    .DIV_TABLE (8'd2)
  ) u_dut2 (
    .CRCU_CLK          (clk),
    .CRCU_RST_N        (rst2_n),
    .tap_clock_ctl_reg (ctl2),
    .tap_clk           (tclk2),
    .tap_clk_active    (act2),
    .tap_switch_busy   (busy2),
    .tap_cfg_err       (err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_step();
    if (pidx == pa) ctl = pav;
    if (pidx == pb) ctl = pbv;
    tick();
    pidx++;
    if (pidx == pa + 1) pbm = busy;
  endtask

  // Starts at the first high sample of a period, returns at the first high
  // sample of the following one.
  task automatic run_period(input int wa, input logic [31:0] wv, input int wb,
                            input logic [31:0] wbv, output int hi, output int lo,
                            output logic bm);
    pa = wa; pav = wv; pb = wb; pbv = wbv; pidx = 0; pbm = 1'b0;
    hi = 0; lo = 0;
    while (tclk === 1'b1 && hi < 300) begin sched_step(); hi++; end
    while (tclk === 1'b0 && lo < 300) begin sched_step(); lo++; end
    bm = pbm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0; ctl = 32'h0; ctl2 = 32'h0;
    tick(); tick();
    checks += 4;
    if (tclk !== 1'b0) begin errors++; $display("FAIL reset_clk got %b want 0", tclk); end
    if (act  !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", act); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (err  !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_start();
    int hi, lo; logic bm;
    rst_n = 1'b1; ctl = 32'h08;
    tick();
    checks++;
    if (tclk !== 1'b0) begin errors++; $display("FAIL start_edge1 got %b want 0", tclk); end
    tick();
    checks += 2;
    if (tclk !== 1'b1) begin errors++; $display("FAIL start_edge2 got %b want 1", tclk); end
    if (act  !== 1'b1) begin errors++; $display("FAIL start_active got %b want 1", act); end
    run_period(10, 32'h0B, -9, 32'h0, hi, lo, bm);
    checks += 3;
    if (hi !== 60) begin errors++; $display("FAIL n120_high got %0d want 60", hi); end
    if (lo !== 60) begin errors++; $display("FAIL n120_low got %0d want 60", lo); end
    if (bm !== 1'b1) begin errors++; $display("FAIL n120_busy got %b want 1", bm); end
  endtask

  task automatic test_switch();
    int hi, lo; logic bm;
    run_period(3, 32'h0C, -9, 32'h0, hi, lo, bm);
    checks += 4;
    if (hi !== 8) begin errors++; $display("FAIL sw15_high got %0d want 8", hi); end
    if (lo !== 7) begin errors++; $display("FAIL sw15_low got %0d want 7", lo); end
    if (bm !== 1'b1) begin errors++; $display("FAIL sw_busy got %b want 1", bm); end
    if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_clear got %b want 0", busy); end
    run_period(-9, 32'h0, -9, 32'h0, hi, lo, bm);
    checks += 2;
    if (hi !== 6) begin errors++; $display("FAIL n12_high got %0d want 6", hi); end
    if (lo !== 6) begin errors++; $display("FAIL n12_low got %0d want 6", lo); end
  endtask

  task automatic test_back_to_back();
    int hi, lo; logic bm;
    // Enable dropped at cnt=2 and restored at cnt=4: period must run on unchanged.
    run_period(2, 32'h04, 4, 32'h0C, hi, lo, bm);
    checks += 5;
    if (hi !== 6) begin errors++; $display("FAIL blip_high got %0d want 6", hi); end
    if (lo !== 6) begin errors++; $display("FAIL blip_low got %0d want 6", lo); end
    if (bm !== 1'b1) begin errors++; $display("FAIL blip_busy got %b want 1", bm); end
    if (act !== 1'b1) begin errors++; $display("FAIL blip_active got %b want 1", act); end
    if (busy !== 1'b0) begin errors++; $display("FAIL blip_busy_clear got %b want 0", busy); end
  endtask

  task automatic test_gate();
    int hi, lo, idx, off_at, glitch; logic bm;
    run_period(0, 32'h09, -9, 32'h0, hi, lo, bm);
    checks += 2;
    if (hi !== 6 || lo !== 6) begin errors++; $display("FAIL pre48_period got %0d/%0d want 6/6", hi, lo); end
    if (bm !== 1'b1) begin errors++; $display("FAIL pre48_busy got %b want 1", bm); end
    hi = 0; idx = 0;
    while (tclk === 1'b1 && hi < 100) begin
      if (idx == 5) ctl = 32'h19;
      tick(); idx++; hi++;
    end
    off_at = -1; glitch = 0;
    for (int i = 0; i < 100; i++) begin
      if (act === 1'b0 && off_at < 0) off_at = idx;
      if (tclk !== 1'b0) glitch++;
      tick(); idx++;
    end
    checks += 3;
    if (hi !== 24) begin errors++; $display("FAIL gate_high got %0d want 24", hi); end
    if (off_at !== 48) begin errors++; $display("FAIL gate_off_at got %0d want 48", off_at); end
    if (glitch !== 0) begin errors++; $display("FAIL gate_glitch got %0d want 0", glitch); end
  endtask

  task automatic test_invalid();
    int hi, lo, glitch; logic bm;
    ctl = 32'h0F;
    tick();
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", err); end
    if (act !== 1'b0) begin errors++; $display("FAIL inv_active got %b want 0", act); end
    if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy got %b want 0", busy); end
    glitch = 0;
    for (int i = 0; i < 6; i++) begin
      if (tclk !== 1'b0 || err !== 1'b1) glitch++;
      tick();
    end
    checks++;
    if (glitch !== 0) begin errors++; $display("FAIL inv_hold got %0d want 0", glitch); end
    ctl = 32'h0A;
    tick();
    checks += 2;
    if (err !== 1'b0) begin errors++; $display("FAIL inv_err_clear got %b want 0", err); end
    if (tclk !== 1'b0) begin errors++; $display("FAIL n30_edge1 got %b want 0", tclk); end
    tick();
    checks++;
    if (tclk !== 1'b1) begin errors++; $display("FAIL n30_edge2 got %b want 1", tclk); end
    run_period(0, 32'h0C, -9, 32'h0, hi, lo, bm);
    checks++;
    if (hi !== 15 || lo !== 15) begin errors++; $display("FAIL n30_period got %0d/%0d want 15/15", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int hi, lo; logic bm;
    tick(); tick();
    checks++;
    if (tclk !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", tclk); end
    rst_n = 1'b0;
    tick();
    checks += 4;
    if (tclk !== 1'b0) begin errors++; $display("FAIL rmid_clk got %b want 0", tclk); end
    if (act  !== 1'b0) begin errors++; $display("FAIL rmid_active got %b want 0", act); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    if (err  !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", err); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (tclk !== 1'b0 || act !== 1'b0) begin errors++; $display("FAIL rrel_edge1 got %b%b want 00", tclk, act); end
    tick();
    checks++;
    if (tclk !== 1'b1) begin errors++; $display("FAIL rrel_edge2 got %b want 1", tclk); end
    run_period(-9, 32'h0, -9, 32'h0, hi, lo, bm);
    checks++;
    if (hi !== 6 || lo !== 6) begin errors++; $display("FAIL rrel_period got %0d/%0d want 6/6", hi, lo); end
  endtask

  task automatic test_div2();
    logic [5:0] got;
    logic [5:0] want;
    want = 6'b101010;
    rst2_n = 1'b1; ctl2 = 32'h08;
    tick(); tick();
    for (int i = 5; i >= 0; i--) begin
      got[i] = tclk2;
      if (i != 0) tick();
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL div2_pattern got %b want %b", got, want); end
    // Now at cnt=1 (low); advance to cnt=0 and disable there.
    tick();
    checks++;
    if (tclk2 !== 1'b1) begin errors++; $display("FAIL div2_cnt0 got %b want 1", tclk2); end
    ctl2 = 32'h00;
    tick();
    checks++;
    if (tclk2 !== 1'b0 || act2 !== 1'b1 || busy2 !== 1'b1)
      begin errors++; $display("FAIL div2_stop1 got clk=%b act=%b busy=%b want 0 1 1", tclk2, act2, busy2); end
    tick();
    checks++;
    if (tclk2 !== 1'b0 || act2 !== 1'b0)
      begin errors++; $display("FAIL div2_stop2 got clk=%b act=%b want 0 0", tclk2, act2); end
    tick(); tick();
    checks++;
    if (tclk2 !== 1'b0) begin errors++; $display("FAIL div2_stay got %b want 0", tclk2); end
    ctl2 = 32'h09;
    tick();
    checks++;
    if (err2 !== 1'b1) begin errors++; $display("FAIL div2_err got %b want 1", err2); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_switch();
    test_back_to_back();
    test_gate();
    test_invalid();
    test_reset_mid();
    test_div2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
